// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: operand forwarding,
// load-use bubbles, branch-redirect flushes, multi-cycle execute stalls and a stall counter.
module pipeline_hazard_ctrl #(
   parameter int REG_W    = 4,
   parameter bit ZERO_REG = 1'b1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] Rs1D,
   input  logic [REG_W-1:0] Rs2D,
   input  logic [REG_W-1:0] Rs1E,
   input  logic [REG_W-1:0] Rs2E,
   input  logic [REG_W-1:0] RdE,
   input  logic [REG_W-1:0] RdM,
   input  logic [REG_W-1:0] RdW,
   input  logic             LoadE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             PCSrcE,
   input  logic             McStartE,
   input  logic             McDoneE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic [CNT_W-1:0] StallCount
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_REDIRECT = 2'd1;
   localparam logic [1:0] ST_MC_BUSY  = 2'd2;

   logic [1:0]       state_reg;
   logic [1:0]       state_next;
   logic [CNT_W-1:0] stall_count_reg;
   logic [CNT_W-1:0] stall_count_next;

   logic rde_valid;
   logic rdm_valid;
   logic rdw_valid;

   // Register 0 is never a real producer when it is hardwired to zero.
   assign rde_valid = (RdE != '0) || !ZERO_REG;
   assign rdm_valid = (RdM != '0) || !ZERO_REG;
   assign rdw_valid = (RdW != '0) || !ZERO_REG;

   logic [1:0][REG_W-1:0] rs_e;
   logic [1:0][REG_W-1:0] rs_d;
   logic [1:0][1:0]       fwd_sel;
   logic [1:0]            d_match;

   assign rs_e = {Rs2E, Rs1E};
   assign rs_d = {Rs2D, Rs1D};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_operand
         // The newer result in M wins over the older one in W.
         assign fwd_sel[gi] = (RegWriteM && rdm_valid && (RdM == rs_e[gi])) ? 2'b10 :
                              (RegWriteW && rdw_valid && (RdW == rs_e[gi])) ? 2'b01 :
                                                                               2'b00;
         assign d_match[gi] = (RdE == rs_d[gi]);
      end
   endgenerate

   logic lw_stall;
   assign lw_stall = LoadE && rde_valid && (d_match != 2'b00);

   logic stall_f;
   logic stall_d;
   logic stall_e;
   logic flush_d;
   logic flush_e;
   logic flush_m;

   always_comb begin
      state_next = state_reg;
      stall_f    = 1'b0;
      stall_d    = 1'b0;
      stall_e    = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      flush_m    = 1'b0;
      case (state_reg)
         ST_RUN: begin
            if (PCSrcE) begin
               flush_d    = 1'b1;
               flush_e    = 1'b1;
               state_next = ST_REDIRECT;
            end else if (McStartE) begin
               // A start that completes in the same cycle behaves like a single-cycle op.
               if (!McDoneE) begin
                  stall_f    = 1'b1;
                  stall_d    = 1'b1;
                  stall_e    = 1'b1;
                  flush_m    = 1'b1;
                  state_next = ST_MC_BUSY;
               end
            end else if (lw_stall) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
            end
         end
         ST_REDIRECT: begin
            // The synchronous IMem already fetched one wrong-path instruction.
            flush_d = 1'b1;
            if (PCSrcE) begin
               flush_e    = 1'b1;
               state_next = ST_REDIRECT;
            end else begin
               state_next = ST_RUN;
            end
         end
         ST_MC_BUSY: begin
            if (McDoneE) begin
               state_next = ST_RUN;
            end else begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               flush_m = 1'b1;
            end
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   assign StallF    = stall_f && !rst;
   assign StallD    = stall_d && !rst;
   assign StallE    = stall_e && !rst;
   assign FlushD    = flush_d && !rst;
   assign FlushE    = flush_e && !rst;
   assign FlushM    = flush_m && !rst;
   assign ForwardAE = rst ? 2'b00 : fwd_sel[0];
   assign ForwardBE = rst ? 2'b00 : fwd_sel[1];

   always_comb begin
      stall_count_next = stall_count_reg;
      if (StallF && (stall_count_reg != '1)) begin
         stall_count_next = stall_count_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_RUN;
         stall_count_reg <= '0;
      end else begin
         state_reg       <= state_next;
         stall_count_reg <= stall_count_next;
      end
   end

   assign StallCount = stall_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table, saturation sequence,
// and randomized cycles against a behavioural model; a second instance uses ZERO_REG=0, CNT_W=4.
module tb_pipeline_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [3:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       LoadE, RegWriteM, RegWriteW, PCSrcE, McStartE, McDoneE;

   logic        a_sf, a_sd, a_se, a_fd, a_fe, a_fm;
   logic [1:0]  a_fa, a_fb;
   logic [15:0] a_cnt;
   logic        b_sf, b_sd, b_se, b_fd, b_fe, b_fm;
   logic [1:0]  b_fa, b_fb;
   logic [3:0]  b_cnt;

   pipeline_hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .McStartE(McStartE), .McDoneE(McDoneE),
      .StallF(a_sf), .StallD(a_sd), .StallE(a_se),
      .FlushD(a_fd), .FlushE(a_fe), .FlushM(a_fm),
      .ForwardAE(a_fa), .ForwardBE(a_fb), .StallCount(a_cnt)
   );

   pipeline_hazard_ctrl #(.REG_W(4), .ZERO_REG(1'b0), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .McStartE(McStartE), .McDoneE(McDoneE),
      .StallF(b_sf), .StallD(b_sd), .StallE(b_se),
      .FlushD(b_fd), .FlushE(b_fe), .FlushM(b_fm),
      .ForwardAE(b_fa), .ForwardBE(b_fb), .StallCount(b_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: which phase the pipeline is in, plus one stall tally per instance.
   bit m_busy, m_redir;
   int m_cnt_a, m_cnt_b;

   function automatic logic [1:0] fwd_model(input bit zr, input logic [3:0] rs);
      if (RegWriteM && (RdM != 0 || !zr) && RdM == rs) return 2'b10;
      if (RegWriteW && (RdW != 0 || !zr) && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   // Returns {StallF,StallD,StallE,FlushD,FlushE,FlushM, ForwardAE, ForwardBE}.
   function automatic logic [9:0] expect_out(input bit zr);
      logic [5:0] c;
      bit lw;
      if (rst) return 10'b0;
      lw = LoadE && (RdE != 0 || !zr) && (RdE == Rs1D || RdE == Rs2D);
      c = 6'b000000;
      if (m_busy)       c = McDoneE ? 6'b000000 : 6'b111001;
      else if (m_redir) c = PCSrcE ? 6'b000110 : 6'b000100;
      else if (PCSrcE)  c = 6'b000110;
      else if (McStartE) c = McDoneE ? 6'b000000 : 6'b111001;
      else if (lw)      c = 6'b110010;
      return {c, fwd_model(zr, Rs1E), fwd_model(zr, Rs2E)};
   endfunction

   task automatic model_advance();
      logic [9:0] ea, eb;
      ea = expect_out(1'b1);
      eb = expect_out(1'b0);
      if (rst) begin
         m_cnt_a = 0; m_cnt_b = 0; m_busy = 0; m_redir = 0;
      end else begin
         if (ea[9] && m_cnt_a < 65535) m_cnt_a++;
         if (eb[9] && m_cnt_b < 15) m_cnt_b++;
         if (m_busy)       m_busy = !McDoneE;
         else if (m_redir) m_redir = PCSrcE;
         else if (PCSrcE)  m_redir = 1;
         else if (McStartE && !McDoneE) m_busy = 1;
      end
   endtask

   task automatic commit();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic clear_inputs();
      rst = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      LoadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; McStartE = 0; McDoneE = 0;
   endtask

   typedef struct {
      logic       r;
      logic [3:0] s1d, s2d, s1e, s2e, de, dm, dw;
      logic       ld, wm, ww, pc, ms, md;
      logic [5:0] ctl;
      logic [1:0] fa, fb;
      int         cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic r, input logic [3:0] s1d, s2d, s1e, s2e, de, dm, dw,
                          input logic ld, wm, ww, pc, ms, md,
                          input logic [5:0] ctl, input logic [1:0] fa, fb, input int cnt);
      vec_t v;
      v.r = r; v.s1d = s1d; v.s2d = s2d; v.s1e = s1e; v.s2e = s2e;
      v.de = de; v.dm = dm; v.dw = dw;
      v.ld = ld; v.wm = wm; v.ww = ww; v.pc = pc; v.ms = ms; v.md = md;
      v.ctl = ctl; v.fa = fa; v.fb = fb; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   initial begin
      logic [9:0] ea, eb;
      m_busy = 0; m_redir = 0; m_cnt_a = 0; m_cnt_b = 0;

      //        r s1d s2d s1e s2e de dm dw  ld wm ww pc ms md  ctl        fa     fb     cnt
      add_vec(1, 0, 0, 3, 0, 0, 3, 0,   0, 1, 0, 1, 0, 0,  6'b000000, 2'b00, 2'b00, 0);
      add_vec(0, 0, 0, 3, 0, 0, 3, 3,   0, 1, 1, 0, 0, 0,  6'b000000, 2'b10, 2'b00, 0);
      add_vec(0, 0, 0, 3, 0, 0, 3, 3,   0, 0, 1, 0, 0, 0,  6'b000000, 2'b01, 2'b00, 0);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0,  6'b000000, 2'b00, 2'b00, 0);
      add_vec(0, 0, 0, 7, 7, 0, 7, 7,   0, 1, 1, 0, 0, 0,  6'b000000, 2'b10, 2'b10, 0);
      add_vec(0, 0, 0, 2, 9, 0, 2, 9,   0, 1, 1, 0, 0, 0,  6'b000000, 2'b10, 2'b01, 0);
      add_vec(0, 0, 5, 0, 0, 5, 0, 0,   1, 0, 0, 0, 0, 0,  6'b110010, 2'b00, 2'b00, 0);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  6'b000000, 2'b00, 2'b00, 1);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,  6'b000000, 2'b00, 2'b00, 1);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0,  6'b000110, 2'b00, 2'b00, 1);
      add_vec(0, 4, 0, 0, 0, 4, 0, 0,   1, 0, 0, 0, 0, 0,  6'b000100, 2'b00, 2'b00, 1);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  6'b000000, 2'b00, 2'b00, 1);
      add_vec(0, 6, 0, 0, 0, 6, 0, 0,   1, 0, 0, 1, 1, 0,  6'b000110, 2'b00, 2'b00, 1);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  6'b000100, 2'b00, 2'b00, 1);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0,  6'b111001, 2'b00, 2'b00, 1);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  6'b111001, 2'b00, 2'b00, 2);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  6'b111001, 2'b00, 2'b00, 3);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  6'b111001, 2'b00, 2'b00, 4);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1,  6'b000000, 2'b00, 2'b00, 5);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  6'b000000, 2'b00, 2'b00, 5);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1,  6'b000000, 2'b00, 2'b00, 5);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  6'b000000, 2'b00, 2'b00, 5);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0,  6'b111001, 2'b00, 2'b00, 5);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0,  6'b111001, 2'b00, 2'b00, 6);
      add_vec(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  6'b000000, 2'b00, 2'b00, 7);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  6'b000000, 2'b00, 2'b00, 0);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0,  6'b000110, 2'b00, 2'b00, 0);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0,  6'b000110, 2'b00, 2'b00, 0);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  6'b000100, 2'b00, 2'b00, 0);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  6'b000000, 2'b00, 2'b00, 0);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0,  6'b000110, 2'b00, 2'b00, 0);
      add_vec(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  6'b000000, 2'b00, 2'b00, 0);
      add_vec(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  6'b000000, 2'b00, 2'b00, 0);

      clear_inputs();
      rst = 1;
      commit();
      commit();

      foreach (vecs[i]) begin
         rst = vecs[i].r; Rs1D = vecs[i].s1d; Rs2D = vecs[i].s2d;
         Rs1E = vecs[i].s1e; Rs2E = vecs[i].s2e;
         RdE = vecs[i].de; RdM = vecs[i].dm; RdW = vecs[i].dw;
         LoadE = vecs[i].ld; RegWriteM = vecs[i].wm; RegWriteW = vecs[i].ww;
         PCSrcE = vecs[i].pc; McStartE = vecs[i].ms; McDoneE = vecs[i].md;
         @(negedge clk);
         $display("vec %0d: ctl=%b%b%b%b%b%b fa=%b fb=%b cnt=%0d", i,
                  a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_fa, a_fb, a_cnt);
         check($sformatf("vec%0d ctl", i), 32'({a_sf, a_sd, a_se, a_fd, a_fe, a_fm}), 32'(vecs[i].ctl));
         check($sformatf("vec%0d fwdA", i), 32'(a_fa), 32'(vecs[i].fa));
         check($sformatf("vec%0d fwdB", i), 32'(a_fb), 32'(vecs[i].fb));
         check($sformatf("vec%0d count", i), 32'(a_cnt), 32'(vecs[i].cnt));
         commit();
      end

      // Saturation: 20 stalled cycles from one multi-cycle op.
      clear_inputs();
      rst = 1;
      commit();
      rst = 0;
      McStartE = 1;
      commit();
      McStartE = 0;
      for (int k = 0; k < 19; k++) commit();
      @(negedge clk);
      $display("sat: cnt=%0d cnt4=%0d stallF=%b", a_cnt, b_cnt, a_sf);
      check("sat count16", 32'(a_cnt), 32'd20);
      check("sat count4", 32'(b_cnt), 32'd15);
      check("sat still busy", 32'(a_sf), 32'd1);
      McDoneE = 1;
      commit();
      McDoneE = 0;
      rst = 1;
      commit();
      rst = 0;
      @(negedge clk);
      $display("sat reset: cnt=%0d cnt4=%0d", a_cnt, b_cnt);
      check("sat reset count16", 32'(a_cnt), 32'd0);
      check("sat reset count4", 32'(b_cnt), 32'd0);
      commit();

      // Randomized cycles against the model for both instances.
      for (int n = 0; n < 300; n++) begin
         rst = ($urandom_range(0, 63) == 0);
         Rs1D = 4'($urandom_range(0, 7)); Rs2D = 4'($urandom_range(0, 7));
         Rs1E = 4'($urandom_range(0, 7)); Rs2E = 4'($urandom_range(0, 7));
         RdE = 4'($urandom_range(0, 7)); RdM = 4'($urandom_range(0, 7));
         RdW = 4'($urandom_range(0, 7));
         LoadE = ($urandom_range(0, 2) == 0);
         RegWriteM = $urandom_range(0, 1) == 1;
         RegWriteW = $urandom_range(0, 1) == 1;
         PCSrcE = ($urandom_range(0, 7) == 0);
         McStartE = ($urandom_range(0, 7) == 0);
         McDoneE = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         ea = expect_out(1'b1);
         eb = expect_out(1'b0);
         $display("rand %0d: rst=%b ctl=%b%b%b%b%b%b fa=%b fb=%b cnt=%0d cnt4=%0d", n, rst,
                  a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_fa, a_fb, a_cnt, b_cnt);
         check($sformatf("rand%0d outs", n),
               32'({a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_fa, a_fb}), 32'(ea));
         check($sformatf("rand%0d outs4", n),
               32'({b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_fa, b_fb}), 32'(eb));
         check($sformatf("rand%0d count", n), 32'(a_cnt), 32'(m_cnt_a));
         check($sformatf("rand%0d count4", n), 32'(b_cnt), 32'(m_cnt_b));
         commit();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
